// File: rtl/ndp_pkg.sv
// Shared constants and FSM encoding for the NDP stream loader and result drain.
// Default geometry: one 4x4 array of FP16 results, returned as 32-bit words.
package ndp_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_ARR_HEIGHT = 4;
  localparam int DEF_ARR_WIDTH  = 4;
  localparam int DEF_SYS_HEIGHT = 1;
  localparam int DEF_SYS_WIDTH  = 1;
  localparam int DEF_BUS_WIDTH  = 32;

  localparam int N_ROWS         = DEF_SYS_HEIGHT * DEF_ARR_HEIGHT;
  localparam int N_COLS         = DEF_SYS_WIDTH * DEF_ARR_WIDTH;
  localparam int TOTAL_BITS     = N_ROWS * N_COLS * DEF_WIDTH;
  localparam int N_WORDS        = TOTAL_BITS / DEF_BUS_WIDTH;
  localparam int ELEMS_PER_WORD = DEF_BUS_WIDTH / DEF_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_e;

  // A single-word drain still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ndp_result_drain.sv
// Snapshots the NDP_core result bus on a calc_done_flag rising edge and streams it
// out as BUS_WIDTH words. Handshake: a word moves on any cycle with valid & ready.
module ndp_result_drain
  import ndp_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ARR_HEIGHT = DEF_ARR_HEIGHT,
  parameter int ARR_WIDTH  = DEF_ARR_WIDTH,
  parameter int SYS_HEIGHT = DEF_SYS_HEIGHT,
  parameter int SYS_WIDTH  = DEF_SYS_WIDTH,
  parameter int BUS_WIDTH  = DEF_BUS_WIDTH
) (
  input  logic                                                     clk,
  input  logic                                                     reset,
  input  logic                                                     calc_done_flag,
  input  logic [SYS_HEIGHT*ARR_HEIGHT*SYS_WIDTH*ARR_WIDTH*WIDTH-1:0] out_c,
  output logic [BUS_WIDTH-1:0]                                     data_out,
  output logic                                                     data_out_valid,
  input  logic                                                     data_out_ready,
  output logic                                                     data_out_last,
  output logic                                                     busy,
  output logic                                                     drain_done,
  output logic                                                     overrun
);

  localparam int DRAIN_BITS  = SYS_HEIGHT * ARR_HEIGHT * SYS_WIDTH * ARR_WIDTH * WIDTH;
  localparam int DRAIN_WORDS = DRAIN_BITS / BUS_WIDTH;
  localparam int CNT_W       = cnt_width(DRAIN_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DRAIN_WORDS - 1);

  drain_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DRAIN_WORDS-1:0][BUS_WIDTH-1:0] snap_q, snap_d;
  logic done_q;
  logic drain_done_q, drain_done_d;
  logic overrun_q, overrun_d;

  logic start;
  logic handshake;
  logic is_last;

  assign start     = calc_done_flag & ~done_q;
  assign is_last   = (cnt_q == LAST_IDX);
  assign handshake = data_out_valid & data_out_ready;

  // Outputs decode straight from state so they are zero whenever IDLE.
  always_comb begin
    data_out_valid = 1'b0;
    busy           = 1'b0;
    data_out_last  = 1'b0;
    data_out       = '0;
    if (state_q == SEND) begin
      data_out_valid = 1'b1;
      busy           = 1'b1;
      data_out_last  = is_last;
      data_out       = snap_q[cnt_q];
    end
  end

  assign drain_done = drain_done_q;
  assign overrun    = overrun_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    snap_d       = snap_q;
    drain_done_d = 1'b0;
    overrun_d    = overrun_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = out_c;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (handshake && is_last) begin
          drain_done_d = 1'b1;
          // A new edge landing on the final handshake chains straight into the next drain.
          if (start) begin
            snap_d = out_c;
            cnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (handshake) cnt_d = cnt_q + 1'b1;
          if (start) overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      snap_q       <= '0;
      done_q       <= 1'b0;
      drain_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      done_q       <= calc_done_flag;
      drain_done_q <= drain_done_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule

// File: doc/ndp_result_drain.md
Name: ndp_result_drain

Overview:
- Output-side counterpart of the NDP_core input stream. The input side carries 32-bit words, each holding two packed FP16 elements, qualified by data_in_flag.
- This block snapshots the parallel result bus out_c when calc_done_flag rises.
- It then streams the snapshot back out as 32-bit words under a valid/ready handshake, with a last marker and a completion pulse.
- It sits between NDP_core and the host/DMA return path.

Parameters:
- WIDTH, 16, bits per result element.
- ARR_HEIGHT, 4, PE rows per systolic array.
- ARR_WIDTH, 4, PE columns per systolic array.
- SYS_HEIGHT, 1, systolic arrays stacked vertically.
- SYS_WIDTH, 1, systolic arrays side by side.
- BUS_WIDTH, 32, output word width; must be a multiple of WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- calc_done_flag  in  1  NDP_core result-ready level; a rising edge starts a drain.
- out_c  in  SYS_HEIGHT*ARR_HEIGHT*SYS_WIDTH*ARR_WIDTH*WIDTH  parallel result from NDP_core.
- data_out  out  BUS_WIDTH  current output word.
- data_out_valid  out  1  data_out holds a valid word.
- data_out_ready  in  1  downstream accepts the word this cycle.
- data_out_last  out  1  high together with valid on the final word of a drain.
- busy  out  1  high while in SEND.
- drain_done  out  1  one-cycle pulse the cycle after the final handshake.
- overrun  out  1  sticky: a calc_done_flag rising edge arrived during a drain and was dropped.

Behaviour:
- Derived constants:
  - TOTAL_BITS = SYS_HEIGHT*ARR_HEIGHT*SYS_WIDTH*ARR_WIDTH*WIDTH.
  - N_WORDS = TOTAL_BITS/BUS_WIDTH; TOTAL_BITS must be divisible by BUS_WIDTH.
  - Word counter width = max(1, clog2(N_WORDS)).
  - Defaults: 256 bits, 8 words.
- Element (r,c) of out_c sits at bit offset (r*SYS_WIDTH*ARR_WIDTH + c)*WIDTH.
- Word w = snapshot[w*BUS_WIDTH +: BUS_WIDTH], so element 2w is in the low half and 2w+1 in the high half. This matches the input packing. No reordering, no arithmetic.
- Edge detect:
  - done_q <= calc_done_flag each cycle; done_q resets to 0.
  - start = calc_done_flag & ~done_q.
  - A flag that is already high on the first cycle after reset counts as an edge.
- Reset values: state=IDLE, word counter=0, data_out_valid=0, data_out_last=0, busy=0, drain_done=0, overrun=0, done_q=0, snapshot=0, data_out=0.
- FSM state IDLE:
  - On start: snapshot <= out_c, counter <= 0, state <= SEND.
  - Latency: valid rises the cycle after the edge is sampled.
- FSM state SEND:
  - data_out_valid=1, busy=1, data_out = word[counter]; data_out_last = (counter == N_WORDS-1).
  - Handshake = valid & ready.
  - On handshake with counter < N_WORDS-1: counter++.
  - Without ready: data_out, valid and last are held stable; valid never drops.
  - Final handshake: drain_done <= 1 for the next cycle only, state <= IDLE.
- Simultaneous events:
  - start in the same cycle as the final handshake: capture the new snapshot, counter <= 0, stay in SEND. drain_done still pulses and overrun is not set. No bubble: valid stays high.
  - start during SEND, not at the final handshake: the edge is ignored and overrun <= 1. overrun clears only on reset.
  - out_c changing during SEND has no effect on the stream.
- Reset mid-drain: the stream aborts immediately and all outputs return to reset values next cycle. No last and no drain_done are emitted.
- N_WORDS = 1: the first word is also last.

Decomposition:
- Shared package ndp_pkg holds:
  - Derived constants: N_ROWS=SYS_HEIGHT*ARR_HEIGHT, N_COLS=SYS_WIDTH*ARR_WIDTH, TOTAL_BITS, N_WORDS, ELEMS_PER_WORD.
  - FSM state encoding (IDLE=0, SEND=1).
- The input-stream loader reuses the same constants.
- Single module; no sub-module needed (the word mux is an indexed part-select).

Test Plan:
- Reset, then out_c = elements 0x0000..0x000F (element i = i), pulse calc_done_flag, ready tied 1 → valid rises the cycle after the edge. Words are 0x00010000, 0x00030002, … 0x000F000E over 8 consecutive cycles. Last on word 7. drain_done one cycle after; busy low after.
- Same stimulus, ready toggling 1,0,0,1,… → each word held stable while ready=0. No word duplicated or skipped. Exactly 8 handshakes.
- Second calc_done_flag rising edge at word 3 → stream unaffected, overrun=1 and remains 1 after drain_done. Next start edge in IDLE drains normally with overrun still 1.
- New rising edge exactly on the final handshake, with out_c changed to 0xAAAA everywhere → drain_done pulses and valid stays high. The next 8 words are 0xAAAAAAAA. overrun stays 0.
- Reset asserted at word 5 → the next cycle valid=0, last=0, busy=0, drain_done=0, overrun=0. A following edge restarts from word 0.
- calc_done_flag held high for 20 cycles → exactly one drain (8 words). No overrun.
